// File: rtl/time_set_ctrl_pkg.sv
// Shared types and BCD digit limits for the time-entry front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package time_set_pkg;

  // Editing state machine states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    LOAD      = 2'd3
  } state_e;

  // BCD field limits for a 24-hour HH:MM value
  localparam logic [1:0] HOUR_TENS_MAX       = 2'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;
  localparam logic [3:0] MIN_TENS_MAX        = 4'd5;
  localparam logic [3:0] DIGIT_MAX           = 4'd9;

endpackage

// File: rtl/time_set_ctrl_if.sv
// Load port carrying the edited HH:MM digits and commit strobes to the clock core.
// Latency: wires only, no storage.
// Backpressure: none; the clock core samples the stretched strobes on its own tick.
// Signals: H_in1/H_in0 hour BCD, M_in1/M_in0 minute BCD, LD_time/LD_alarm commit strobes.
interface time_set_ctrl_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;

  // master: the time-entry block driving the load port
  modport master (output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
  // slave: the clock core consuming the load port
  modport slave  (input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// Raw push button -> 2-flop sync -> stable-count debouncer -> one-cycle press pulse.
// Latency: pulse is high DEBOUNCE_CYCLES+2 cycles after the first edge sampling the new level.
// Backpressure: none; a pulse not consumed in its cycle is lost. Release gives no pulse.
// Ports: clk, rst_n (async active-low), i_btn raw level, o_press registered press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the accepted level restarts the count,
      // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-entry front end: debounced buttons edit an HH:MM BCD value and commit it to the clock core.
// Latency: button action lands 1 cycle after its press pulse; LD rises 1 cycle after entering LOAD.
// Backpressure: none; presses during LOAD are dropped, LD is held LOAD_HOLD cycles for the slow core tick.
// Ports: clk, reset (async active-low), btn_mode/btn_next/btn_inc/btn_set raw buttons,
//        ld_bus load port (digits + LD_time/LD_alarm), editing, field_sel (1=minutes), target (1=alarm).
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int LOAD_HOLD       = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_mode,
  input  logic                  btn_next,
  input  logic                  btn_inc,
  input  logic                  btn_set,
  time_set_ctrl_if.master       ld_bus,
  output logic                  editing,
  output logic                  field_sel,
  output logic                  target
);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_EDIT_HOUR = EDIT_HOUR;
  localparam logic [1:0] S_EDIT_MIN  = EDIT_MIN;
  localparam logic [1:0] S_LOAD      = LOAD;

  localparam int LW = $clog2(LOAD_HOLD + 1);

  logic [1:0]    r_state;
  logic          r_target;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0;
  logic [3:0]    r_m1;
  logic [3:0]    r_m0;
  logic [LW-1:0] r_ld_cnt;
  logic          r_ld_time;
  logic          r_ld_alarm;

  logic w_p_mode, w_p_next, w_p_inc, w_p_set;
  logic w_mode, w_next, w_inc, w_set;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(reset), .i_btn(btn_mode), .o_press(w_p_mode));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(reset), .i_btn(btn_next), .o_press(w_p_next));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(reset), .i_btn(btn_inc), .o_press(w_p_inc));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .rst_n(reset), .i_btn(btn_set), .o_press(w_p_set));

  // Same-cycle presses: only the highest priority survives (set > mode > next > inc)
  assign w_set  = w_p_set;
  assign w_mode = w_p_mode & ~w_p_set;
  assign w_next = w_p_next & ~w_p_set & ~w_p_mode;
  assign w_inc  = w_p_inc  & ~w_p_set & ~w_p_mode & ~w_p_next;

  // 23 -> 00, otherwise BCD +1 with units carry into tens
  function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] u);
    if (t == HOUR_TENS_MAX && u == HOUR_UNITS_MAX_AT_2) begin
      return 6'd0;
    end else if (u == DIGIT_MAX) begin
      return {t + 2'd1, 4'd0};
    end else begin
      return {t, u + 4'd1};
    end
  endfunction

  // 59 -> 00, otherwise BCD +1 with units carry into tens
  function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
    if (t == MIN_TENS_MAX && u == DIGIT_MAX) begin
      return 8'd0;
    end else if (u == DIGIT_MAX) begin
      return {t + 4'd1, 4'd0};
    end else begin
      return {t, u + 4'd1};
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_target   <= 1'b0;
      r_h1       <= '0;
      r_h0       <= '0;
      r_m1       <= '0;
      r_m0       <= '0;
      r_ld_cnt   <= '0;
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_state  <= S_EDIT_HOUR;
            r_target <= 1'b0;
          end
        end
        S_EDIT_HOUR, S_EDIT_MIN: begin
          if (w_set) begin
            r_state  <= S_LOAD;
            r_ld_cnt <= '0;
          end else if (w_mode) begin
            r_target <= ~r_target;
          end else if (w_next) begin
            r_state <= (r_state == S_EDIT_HOUR) ? S_EDIT_MIN : S_EDIT_HOUR;
          end else if (w_inc) begin
            if (r_state == S_EDIT_HOUR) begin
              {r_h1, r_h0} <= hour_inc(r_h1, r_h0);
            end else begin
              {r_m1, r_m0} <= min_inc(r_m1, r_m0);
            end
          end
        end
        S_LOAD: begin
          // Strobe is registered one cycle behind LOAD entry and counts
          // LOAD_HOLD cycles high; digits are untouched in this state.
          if (r_ld_cnt == LW'(LOAD_HOLD)) begin
            r_state    <= S_IDLE;
            r_ld_cnt   <= '0;
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
          end else begin
            r_ld_cnt   <= r_ld_cnt + 1'b1;
            r_ld_time  <= ~r_target;
            r_ld_alarm <= r_target;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_bus.H_in1    = r_h1;
  assign ld_bus.H_in0    = r_h0;
  assign ld_bus.M_in1    = r_m1;
  assign ld_bus.M_in0    = r_m0;
  assign ld_bus.LD_time  = r_ld_time;
  assign ld_bus.LD_alarm = r_ld_alarm;

  assign editing   = (r_state == S_EDIT_HOUR) || (r_state == S_EDIT_MIN);
  assign field_sel = (r_state == S_EDIT_MIN);
  assign target    = r_target;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: model predicts output changes and commit strobes.
// Latency: n/a.
// Backpressure: n/a.
module tb_time_set_ctrl;

  localparam int DEB  = 8;
  localparam int HOLD = 12;

  localparam int B_MODE = 0;
  localparam int B_NEXT = 1;
  localparam int B_INC  = 2;
  localparam int B_SET  = 3;

  localparam int M_IDLE = 0;
  localparam int M_HOUR = 1;
  localparam int M_MIN  = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic       editing, field_sel, target;

  time_set_ctrl_if ld_bus();

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .LOAD_HOLD(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn[0]),
    .btn_next (btn[1]),
    .btn_inc  (btn[2]),
    .btn_set  (btn[3]),
    .ld_bus   (ld_bus),
    .editing  (editing),
    .field_sel(field_sel),
    .target   (target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h1, h0, m1, m0;
    int ed, fs, tg;
  } snap_t;

  typedef struct {
    int alarm;
    int digits;
  } ld_t;

  snap_t q_snap[$];
  ld_t   q_ld[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain hour/minute integers and an abstract mode
  int m_state = M_IDLE;
  int m_hour  = 0;
  int m_min   = 0;
  int m_tgt   = 0;
  bit in_reset = 1'b1;

  function automatic void check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic int enc_digits(input int h1, input int h0, input int m1, input int m0);
    return (h1 << 12) | (h0 << 8) | (m1 << 4) | m0;
  endfunction

  function automatic int enc_snap(input snap_t s);
    return (enc_digits(s.h1, s.h0, s.m1, s.m0) << 4) | (s.ed << 2) | (s.fs << 1) | s.tg;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.h1 = m_hour / 10;
    s.h0 = m_hour % 10;
    s.m1 = m_min / 10;
    s.m0 = m_min % 10;
    s.ed = (m_state != M_IDLE) ? 1 : 0;
    s.fs = (m_state == M_MIN) ? 1 : 0;
    s.tg = m_tgt;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.h1 = int'(ld_bus.H_in1);
    s.h0 = int'(ld_bus.H_in0);
    s.m1 = int'(ld_bus.M_in1);
    s.m0 = int'(ld_bus.M_in0);
    s.ed = int'(editing);
    s.fs = int'(field_sel);
    s.tg = int'(target);
    return s;
  endfunction

  // Apply one accepted press to the model and queue every visible consequence
  function automatic void model_press(input int b);
    ld_t l;
    if (m_state == M_IDLE) begin
      if (b == B_MODE) begin
        m_state = M_HOUR;
        m_tgt   = 0;
        q_snap.push_back(model_snap());
      end
    end else begin
      case (b)
        B_MODE: m_tgt = 1 - m_tgt;
        B_NEXT: m_state = (m_state == M_HOUR) ? M_MIN : M_HOUR;
        B_INC: begin
          if (m_state == M_HOUR) m_hour = (m_hour + 1) % 24;
          else                   m_min  = (m_min + 1) % 60;
        end
        default: begin
          l.alarm  = m_tgt;
          l.digits = enc_digits(m_hour / 10, m_hour % 10, m_min / 10, m_min % 10);
          q_ld.push_back(l);
          m_state = M_IDLE;
        end
      endcase
      q_snap.push_back(model_snap());
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_btns(input logic [3:0] mask, input int hold, input int gap);
    if      (mask[3]) model_press(B_SET);
    else if (mask[0]) model_press(B_MODE);
    else if (mask[1]) model_press(B_NEXT);
    else if (mask[2]) model_press(B_INC);
    btn = mask;
    step(hold);
    btn = 4'b0000;
    step(gap);
  endtask

  task automatic press(input int b);
    press_btns(4'(1 << b), int'($urandom_range(14, 20)), int'($urandom_range(14, 20)));
  endtask

  // Monitor: output snapshots and strobe pulses, compared against the queues
  snap_t last_s;
  int    ld_act   = 0;
  int    ld_len   = 0;
  int    ld_kind  = 0;
  int    ld_dig   = 0;
  int    ld_moved = 0;

  always @(negedge clk) begin
    snap_t cur;
    snap_t e;
    ld_t   l;
    int    lt, la, dg;
    cur = dut_snap();
    lt  = int'(ld_bus.LD_time);
    la  = int'(ld_bus.LD_alarm);
    dg  = enc_digits(cur.h1, cur.h0, cur.m1, cur.m0);
    if (in_reset) begin
      last_s = cur;
      ld_act = 0;
    end else begin
      if (enc_snap(cur) != enc_snap(last_s)) begin
        if (q_snap.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_change: got %0h expected no change at %0t", enc_snap(cur), $time);
        end else begin
          e = q_snap.pop_front();
          check("snapshot", enc_snap(cur), enc_snap(e));
        end
      end
      last_s = cur;

      if (lt != 0 || la != 0) check("ld_exclusive", lt & la, 0);

      if (ld_act == 0) begin
        if (lt != 0 || la != 0) begin
          ld_act   = 1;
          ld_len   = 1;
          ld_kind  = la;
          ld_dig   = dg;
          ld_moved = 0;
        end
      end else if ((ld_kind != 0 ? la : lt) != 0) begin
        ld_len++;
        if (dg != ld_dig) ld_moved = 1;
      end else begin
        ld_act = 0;
        if (q_ld.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_strobe: got alarm=%0d len=%0d expected none at %0t", ld_kind, ld_len, $time);
        end else begin
          l = q_ld.pop_front();
          check("ld_target", ld_kind, l.alarm);
          check("ld_length", ld_len, HOLD);
          check("ld_digits", ld_dig, l.digits);
          check("ld_digits_stable", ld_moved, 0);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values
    step(3);
    check("rst_H_in1", int'(ld_bus.H_in1), 0);
    check("rst_H_in0", int'(ld_bus.H_in0), 0);
    check("rst_M_in1", int'(ld_bus.M_in1), 0);
    check("rst_M_in0", int'(ld_bus.M_in0), 0);
    check("rst_LD_time", int'(ld_bus.LD_time), 0);
    check("rst_LD_alarm", int'(ld_bus.LD_alarm), 0);
    check("rst_editing", int'(editing), 0);
    check("rst_field_sel", int'(field_sel), 0);
    check("rst_target", int'(target), 0);
    reset = 1'b1;
    step(2);
    in_reset = 1'b0;
    step(2);

    // Enter edit with a 20-cycle mode hold
    press_btns(4'b0001, 20, 20);

    // Hour wrap: 24 increments, 23 seen on the way
    for (int i = 0; i < 24; i++) press(B_INC);

    // Minute field: 60 increments through 09->10 and 59->00
    press(B_NEXT);
    for (int i = 0; i < 60; i++) press(B_INC);

    // Dial in 07:45, switch to alarm, commit
    press(B_NEXT);
    for (int i = 0; i < 7; i++) press(B_INC);
    press(B_NEXT);
    for (int i = 0; i < 45; i++) press(B_INC);
    press(B_MODE);
    press(B_SET);

    // Short glitch on inc must not edit
    press(B_MODE);
    btn[B_INC] = 1'b1;
    step(5);
    btn = 4'b0000;
    step(25);

    // set and inc together: set wins, digits unchanged
    press_btns(4'b1100, 18, 20);

    // inc arriving while LOAD is in progress is dropped
    press(B_MODE);
    model_press(B_SET);
    btn[B_SET] = 1'b1;
    step(5);
    btn[B_INC] = 1'b1;
    step(15);
    btn = 4'b0000;
    step(25);

    // Reset during LOAD: strobe dies at once, nothing follows
    press(B_MODE);
    model_press(B_SET);
    btn[B_SET] = 1'b1;
    k = 0;
    while (ld_bus.LD_time !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    check("ld_rise_in_budget", (k < 40) ? 1 : 0, 1);
    step(3);
    reset    = 1'b0;
    in_reset = 1'b1;
    btn      = 4'b0000;
    #1;
    check("arst_LD_time", int'(ld_bus.LD_time), 0);
    check("arst_LD_alarm", int'(ld_bus.LD_alarm), 0);
    check("arst_digits", enc_digits(int'(ld_bus.H_in1), int'(ld_bus.H_in0),
                                    int'(ld_bus.M_in1), int'(ld_bus.M_in0)), 0);
    check("arst_editing", int'(editing), 0);
    check("arst_field_sel", int'(field_sel), 0);
    check("arst_target", int'(target), 0);
    m_state = M_IDLE;
    m_hour  = 0;
    m_min   = 0;
    m_tgt   = 0;
    q_ld.delete();
    step(3);
    reset = 1'b1;
    step(1);
    in_reset = 1'b0;
    step(40);

    // Randomized button traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if      (r < 2) press(B_MODE);
      else if (r < 4) press(B_NEXT);
      else if (r < 9) press(B_INC);
      else            press(B_SET);
    end

    // Drain outstanding expectations
    k = 0;
    while ((q_snap.size() != 0 || q_ld.size() != 0) && k < 300) begin
      step(1);
      k++;
    end
    check("drain_pending", q_snap.size() + q_ld.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User time-entry front end for the digital clock: debounces four push buttons, lets the user edit an HH:MM value in BCD with wrap-around, then commits it to the clock core's load port (H_in1/H_in0/M_in1/M_in0 with LD_time or LD_alarm). It drives the clock's load port, whose outputs drive the display. LD pulses are stretched so the clock core's divided 1 s tick samples them.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 8: consecutive stable synchronized samples required to accept a button level change.
- LOAD_HOLD, 12: clk cycles LD_time/LD_alarm stay high on commit; must exceed one full clock-core tick period (10 clk).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw button, active-high, asynchronous to clk.
- btn_next  in  1  raw button, active-high, asynchronous.
- btn_inc  in  1  raw button, active-high, asynchronous.
- btn_set  in  1  raw button, active-high, asynchronous.
- H_in1  out  2  edited hour tens (0..2).
- H_in0  out  4  edited hour units (0..9; 0..3 when H_in1=2).
- M_in1  out  4  edited minute tens (0..5).
- M_in0  out  4  edited minute units (0..9).
- LD_time  out  1  commit strobe to the clock time registers.
- LD_alarm  out  1  commit strobe to the alarm registers.
- editing  out  1  high in EDIT_HOUR/EDIT_MIN.
- field_sel  out  1  0 = hour field active, 1 = minute field active.
- target  out  1  0 = time, 1 = alarm.

## Operation
- Each button: 2-flop synchronizer -> debouncer -> one-cycle press pulse on the rising edge of the debounced level. Release produces no pulse.
- Same-cycle press priority: set > mode > next > inc. Lower-priority pulses in that cycle are discarded.
- States: IDLE, EDIT_HOUR, EDIT_MIN, LOAD.
- IDLE:
  - mode -> EDIT_HOUR with target=0.
  - next, inc and set are ignored.
- EDIT_HOUR / EDIT_MIN:
  - mode toggles target.
  - next moves EDIT_HOUR -> EDIT_MIN, or EDIT_MIN -> EDIT_HOUR.
  - inc increments the active field.
  - set -> LOAD.
- LOAD:
  - Asserts LD_time if target=0, else LD_alarm, for exactly LOAD_HOLD cycles, then -> IDLE.
  - All presses in LOAD are dropped.
  - Digits are frozen throughout LOAD.
- Hour increment (BCD): 23 -> 00; if H_in0=9, units -> 0 and tens +1; otherwise units +1.
- Minute increment (BCD): 59 -> 00; if M_in0=9, units -> 0 and tens +1; otherwise units +1.
- Digit outputs always reflect the edit registers, including in IDLE. They are never cleared on commit, so the next edit starts from the last committed value.
- LD_time and LD_alarm are never high simultaneously.

## Timing
- Reset values (asynchronous): all digits 0; LD_time=0, LD_alarm=0, editing=0, field_sel=0, target=0; state IDLE; debounced levels 0; debounce counters 0.
- Debounce counter: resets whenever the synchronized level equals the debounced level. It increments while they differ. At count DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Latency: press pulse is high in cycle DEBOUNCE_CYCLES+2 after the first clk edge that samples the new raw level. A glitch shorter than DEBOUNCE_CYCLES samples yields no pulse.
- Field action (digit change, state change, target toggle) is registered on the edge ending the pulse cycle, i.e. 1 cycle after the pulse.
- LD asserts the cycle after entering LOAD. Digits are stable from at least 1 cycle before LD rises until LD falls.
- Reset asserted mid-LOAD: LD drops immediately and asynchronously; no further strobe is issued.

## Structure
- Package time_set_pkg:
  - state enum (IDLE, EDIT_HOUR, EDIT_MIN, LOAD).
  - BCD limits: HOUR_TENS_MAX=2, HOUR_UNITS_MAX_AT_2=3, MIN_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module btn_debounce (synchronizer + counter + press pulse), parameterized by DEBOUNCE_CYCLES, instantiated four times.
- FSM, BCD incrementers and LD stretch counter live in the top module.

## Test plan
- Reset, then hold btn_mode 20 cycles -> editing=1, field_sel=0, target=0, digits 00:00.
- From 00:00 in EDIT_HOUR, 24 inc presses -> hour wraps to 00. At the 23rd press the hour reads 23 (H_in1=2, H_in0=3).
- next, then 60 inc presses -> minute passes 09 -> 10 and 59 -> 00. Hour is unchanged.
- Set 07:45, mode (target=1), set -> LD_alarm high exactly LOAD_HOLD=12 cycles, LD_time stays 0, digits read 07:45 throughout, then state IDLE.
- btn_inc glitch of 5 cycles -> no increment. btn_set and btn_inc pressed in the same debounced cycle -> LOAD entered, digits unchanged.
- Assert reset 4 cycles into LOAD -> LD_time falls asynchronously, all outputs take reset values, and no strobe follows reset release.
